// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding the display scanner.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk_original,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_cap_q, sign_cap_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_out_q, sign_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_scr;
  logic [WIDTH-1:0]   step_bin;

  // One double-dabble step: add 3 to nibbles >= 5, then shift binary into scratch.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    {step_scr, step_bin} = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    sign_cap_d = sign_cap_q;
    bcd_d      = bcd_q;
    sign_out_d = sign_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d    = bin_in;
          sign_cap_d = sign_in;
          scr_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d = step_bin;
        scr_d   = step_scr;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d      = step_scr;
          sign_out_d = sign_cap_q;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_original) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_cap_q <= 1'b0;
      bcd_q      <= '0;
      sign_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      sign_cap_q <= sign_cap_d;
      bcd_q      <= bcd_d;
      sign_out_q <= sign_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign sign_out = sign_out_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
  logic              upper_zero;

  // Digit i blanks when it and all more-significant digits are zero; ones never blanks.
  always_comb begin
    blank_calc = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (step_scr[4*i +: 4] == 4'd0);
      blank_calc[i] = upper_zero;
    end
    blank_d = blank_q;
    if (state_q == SHIFT && cnt_q == CNT_W'(1)) blank_d = blank_calc;
  end

  always_ff @(posedge clk_original) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule
